// File: rtl/alu_sequencer_pkg.sv
// Shared ALU control codes and MIPS R-type funct constants for the ALU sequencer.
package alu_sequencer_pkg;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_NOOP = 6'h2C;

  localparam logic [2:0] CTL_AND  = 3'b000;
  localparam logic [2:0] CTL_OR   = 3'b001;
  localparam logic [2:0] CTL_ADD  = 3'b010;
  localparam logic [2:0] CTL_XOR  = 3'b011;
  localparam logic [2:0] CTL_NOR  = 3'b100;
  localparam logic [2:0] CTL_NOOP = 3'b101;
  localparam logic [2:0] CTL_SUB  = 3'b110;
  localparam logic [2:0] CTL_SLT  = 3'b111;
  // Only eight codes fit in 3 bits; ERROR parks the ALU on NOOP.
  localparam logic [2:0] CTL_ERROR = CTL_NOOP;

  function automatic logic [2:0] idle_ctl(input bit idle_noop);
    return idle_noop ? CTL_NOOP : CTL_AND;
  endfunction

endpackage

// File: rtl/alu_sequencer_funct.sv
// Combinational MIPS funct to ALU control encoder.
module alu_funct_encoder
  import alu_sequencer_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] ctl,
  output logic       illegal
);

  always_comb begin
    ctl     = CTL_ERROR;
    illegal = 1'b0;
    case (funct)
      FUNCT_ADD:  ctl = CTL_ADD;
      FUNCT_SUB:  ctl = CTL_SUB;
      FUNCT_AND:  ctl = CTL_AND;
      FUNCT_OR:   ctl = CTL_OR;
      FUNCT_XOR:  ctl = CTL_XOR;
      FUNCT_NOR:  ctl = CTL_NOR;
      FUNCT_SLT:  ctl = CTL_SLT;
      FUNCT_NOOP: ctl = CTL_NOOP;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences narrow/wide R-type operations through an external 32-bit
// combinational ALU, one or two passes per request.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter bit IDLE_NOOP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic        req_wide,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_res,
  output logic        rsp_zero,
  output logic        rsp_ovf,
  output logic        rsp_cout,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  output logic [2:0]  alu_ctl,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  input  logic        alu_cout
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t      state, state_next;
  logic        started;
  logic [2:0]  enc_ctl;
  logic        enc_illegal;
  logic        accept;
  logic        req_err;
  logic        req_noop;
  logic        req_wsub;

  logic [2:0]  op_ctl;
  logic        op_wide;
  logic        op_inv_b;
  logic        op_chain;
  logic [63:0] a_q;
  logic [63:0] b_q;

  alu_funct_encoder u_enc (
    .funct   (req_funct),
    .ctl     (enc_ctl),
    .illegal (enc_illegal)
  );

  assign req_ready = started && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign req_err   = enc_illegal || (req_wide && (enc_ctl == CTL_SLT));
  assign req_noop  = !enc_illegal && (enc_ctl == CTL_NOOP);
  assign req_wsub  = req_wide && (enc_ctl == CTL_SUB);

  // Holds req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) started <= 1'b0;
    else        started <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_a      = '0;
    alu_b      = '0;
    alu_cin    = 1'b0;
    alu_ctl    = idle_ctl(IDLE_NOOP);
    case (state)
      IDLE: begin
        if (accept) state_next = (req_err || req_noop) ? RESP : LO;
      end
      LO: begin
        alu_a      = a_q[31:0];
        alu_b      = op_inv_b ? ~b_q[31:0] : b_q[31:0];
        alu_cin    = op_inv_b;
        alu_ctl    = op_ctl;
        state_next = op_wide ? HI : RESP;
      end
      HI: begin
        // rsp_cout still holds the LO carry here and feeds the upper half.
        alu_a      = a_q[63:32];
        alu_b      = op_inv_b ? ~b_q[63:32] : b_q[63:32];
        alu_cin    = op_chain && rsp_cout;
        alu_ctl    = op_ctl;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_ctl   <= CTL_NOOP;
      op_wide  <= 1'b0;
      op_inv_b <= 1'b0;
      op_chain <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rsp_res  <= '0;
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
      rsp_cout <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Wide SUB runs as two chained ADD passes of a + ~b + 1.
            op_ctl   <= req_wsub ? CTL_ADD : enc_ctl;
            op_wide  <= req_wide;
            op_inv_b <= req_wsub;
            op_chain <= req_wide && ((enc_ctl == CTL_ADD) || (enc_ctl == CTL_SUB));
            a_q      <= req_a;
            b_q      <= req_b;
            rsp_res  <= '0;
            rsp_zero <= 1'b0;
            rsp_ovf  <= 1'b0;
            rsp_cout <= 1'b0;
            rsp_err  <= req_err;
          end
        end
        LO: begin
          rsp_res  <= {32'b0, alu_res};
          rsp_zero <= alu_zero;
          rsp_ovf  <= alu_ovf;
          rsp_cout <= alu_cout;
        end
        HI: begin
          rsp_res[63:32] <= alu_res;
          rsp_zero       <= rsp_zero && alu_zero;
          rsp_ovf        <= alu_ovf;
          rsp_cout       <= alu_cout;
        end
        default: ;
      endcase
    end
  end

endmodule
